// File: rtl/max_frame_sched.sv
// max_frame_sched: frame-based running-maximum scheduler.
// Accepts cfg_len samples over a valid/ready stream, tracks the maximum and
// the 0-based index of its first occurrence, and presents {max, index} on a
// registered valid/ready output port when the frame ends.
// Optional build macro: MAX_FRAME_SCHED_SIGNED_EN selects a two's-complement
// compare. Without it, the compare is unsigned.
module max_frame_sched #(
  parameter int DATA_W = 6,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_max,
  output logic [LEN_W-1:0]  out_idx,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DONE} state_t;

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_t              r_state;
  state_t              w_next;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_cnt;
  logic [DATA_W-1:0]   r_cur_max;
  logic [LEN_W-1:0]    r_cur_idx;
  logic [DATA_W-1:0]   r_out_max;
  logic [LEN_W-1:0]    r_out_idx;
  logic                r_out_valid;

  logic                w_start_ok;
  logic                w_load;
  logic                w_acc;
  logic                w_last;
  logic                w_take;
  logic [DATA_W-1:0]   w_new_max;
  logic [LEN_W-1:0]    w_new_idx;

  // Strict greater-than; the signedness is the only build-time difference.
  function automatic logic gt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
`ifdef MAX_FRAME_SCHED_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  assign w_start_ok = start && (cfg_len != '0);
  // A new frame may begin from IDLE, or from DONE on the output-handshake cycle.
  assign w_load     = w_start_ok &&
                      ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready));
  assign w_acc      = in_valid && (r_state == S_ACCUM);
  assign w_last     = (r_cnt == (r_len - ONE));
  // The first sample of a frame loads unconditionally; ties keep the earlier index.
  assign w_take     = (r_cnt == '0) || gt(in_data, r_cur_max);
  assign w_new_max  = w_take ? in_data : r_cur_max;
  assign w_new_idx  = w_take ? r_cnt   : r_cur_idx;

  assign in_ready   = (r_state == S_ACCUM);
  assign busy       = (r_state != S_IDLE);
  assign out_valid  = r_out_valid;
  assign out_max    = r_out_max;
  assign out_idx    = r_out_idx;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok)       w_next = S_ACCUM;
      S_ACCUM: if (w_acc && w_last)  w_next = S_DONE;
      S_DONE:  if (out_ready)        w_next = w_start_ok ? S_ACCUM : S_IDLE;
      default:                       w_next = S_IDLE;
    endcase
  end

  // Frame length, sample counter and running maximum/index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len     <= '0;
      r_cnt     <= '0;
      r_cur_max <= '0;
      r_cur_idx <= '0;
    end else if (w_load) begin
      r_len <= cfg_len;
      r_cnt <= '0;
    end else if (w_acc) begin
      r_cnt     <= r_cnt + ONE;
      r_cur_max <= w_new_max;
      r_cur_idx <= w_new_idx;
    end
  end

  // Result registers: captured on the final accept and held until the next frame ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_max <= '0;
      r_out_idx <= '0;
    end else if (w_acc && w_last) begin
      r_out_max <= w_new_max;
      r_out_idx <= w_new_idx;
    end
  end

  // Registered result-valid: set on the final accept, cleared by the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         r_out_valid <= 1'b0;
    else if (w_acc && w_last)           r_out_valid <= 1'b1;
    else if (r_out_valid && out_ready)  r_out_valid <= 1'b0;
  end

endmodule

// File: tb/tb_max_frame_sched.sv
// Directed testbench for max_frame_sched with a result scoreboard.
module tb_max_frame_sched;

  localparam int DATA_W = 6;
  localparam int LEN_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [LEN_W-1:0]  cfg_len = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_max;
  logic [LEN_W-1:0]  out_idx;
  logic              busy;

  typedef struct packed {
    logic [DATA_W-1:0] m;
    logic [LEN_W-1:0]  i;
  } res_t;

  res_t sb[$];
  int   checks = 0;
  int   errors = 0;

  max_frame_sched #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_max(out_max),
    .out_idx(out_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h required %0h", tag, got, exp);
    end
  endtask

  function automatic logic gt_m(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
`ifdef MAX_FRAME_SCHED_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  // Reference model: first strict maximum over the first n samples.
  task automatic model_push(input logic [DATA_W-1:0] s [8], input int n);
    res_t r;
    r.m = s[0];
    r.i = '0;
    for (int k = 1; k < n; k++) begin
      if (gt_m(s[k], r.m)) begin
        r.m = s[k];
        r.i = LEN_W'(k);
      end
    end
    sb.push_back(r);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [LEN_W-1:0] len);
    start   = 1'b1;
    cfg_len = len;
    tick();
    start   = 1'b0;
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) begin
      checks++;
      errors++;
      $error("FAIL send_timeout got in_ready=%b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    in_data  = DATA_W'($urandom);
  endtask

  // Scoreboard: compare each handshaken result against the oldest expectation.
  always @(negedge clk) begin
    res_t e;
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_result got %0h/%0h required none", out_max, out_idx);
      end else begin
        e = sb.pop_front();
        chk("sb_max", 32'(out_max), 32'(e.m));
        chk("sb_idx", 32'(out_idx), 32'(e.i));
      end
    end
  end

  initial begin
    // Reset values
    #1;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_max", 32'(out_max), 0);
    chk("rst_out_idx", 32'(out_idx), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_in_ready", 32'(in_ready), 0);

    // Basic frame
    model_push('{6'd3, 6'd9, 6'd2, 6'd7, 6'd0, 6'd0, 6'd0, 6'd0}, 4);
    do_start(8'd4);
    chk("basic_busy", 32'(busy), 1);
    chk("basic_in_ready", 32'(in_ready), 1);
    send(6'd3, 0); send(6'd9, 0); send(6'd2, 0);
    chk("basic_not_done", 32'(out_valid), 0);
    send(6'd7, 0);
    chk("basic_out_valid", 32'(out_valid), 1);
    chk("basic_done_in_ready", 32'(in_ready), 0);
    chk("basic_max", 32'(out_max), 9);
    chk("basic_idx", 32'(out_idx), 1);
    tick();
    chk("basic_valid_drop", 32'(out_valid), 0);
    chk("basic_idle_busy", 32'(busy), 0);

    // Ties and bubbles, result held under backpressure
    out_ready = 1'b0;
    model_push('{6'd5, 6'd12, 6'd12, 6'd0, 6'd12, 6'd0, 6'd0, 6'd0}, 5);
    do_start(8'd5);
    send(6'd5, 0); send(6'd12, 1); send(6'd12, 3); send(6'd0, 2);
    chk("ties_not_done", 32'(out_valid), 0);
    send(6'd12, 0);
    chk("ties_out_valid", 32'(out_valid), 1);
    for (int k = 0; k < 6; k++) begin
      start   = 1'b1;
      cfg_len = 8'd2;
      tick();
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_max", 32'(out_max), 12);
      chk("bp_idx", 32'(out_idx), 1);
      chk("bp_in_ready", 32'(in_ready), 0);
    end
    // Handshake together with start: straight into the next frame
    out_ready = 1'b1;
    model_push('{6'd1, 6'd63, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0}, 2);
    tick();
    start = 1'b0;
    chk("b2b_in_ready", 32'(in_ready), 1);
    chk("b2b_busy", 32'(busy), 1);
    chk("b2b_valid_drop", 32'(out_valid), 0);
    send(6'd1, 0); send(6'd63, 0);
    chk("b2b_out_valid", 32'(out_valid), 1);
    chk("b2b_max", 32'(out_max), 63);
    chk("b2b_idx", 32'(out_idx), 1);
    tick();
    chk("b2b_idle", 32'(busy), 0);
    chk("hold_max", 32'(out_max), 63);

    // Reset mid-frame
    do_start(8'd4);
    send(6'd8, 0); send(6'd5, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_max", 32'(out_max), 0);
    chk("mid_rst_idx", 32'(out_idx), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_idle", 32'(busy), 0);
    model_push('{6'd4, 6'd1, 6'd4, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0}, 3);
    do_start(8'd3);
    send(6'd4, 0); send(6'd1, 0); send(6'd4, 0);
    chk("restart_max", 32'(out_max), 4);
    chk("restart_idx", 32'(out_idx), 0);
    tick();

    // Zero length is ignored
    start   = 1'b1;
    cfg_len = 8'd0;
    tick();
    start = 1'b0;
    chk("len0_busy", 32'(busy), 0);
    chk("len0_in_ready", 32'(in_ready), 0);
    tick();
    chk("len0_still_idle", 32'(busy), 0);

    // Single-sample frame
    model_push('{6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0}, 1);
    do_start(8'd1);
    send(6'd0, 0);
    chk("len1_valid", 32'(out_valid), 1);
    chk("len1_max", 32'(out_max), 0);
    chk("len1_idx", 32'(out_idx), 0);
    tick();

    // Signedness-dependent frame
    model_push('{6'h3F, 6'h20, 6'h01, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0}, 3);
    do_start(8'd3);
    send(6'h3F, 0); send(6'h20, 0); send(6'h01, 0);
`ifdef MAX_FRAME_SCHED_SIGNED_EN
    chk("sign_max", 32'(out_max), 32'h01);
    chk("sign_idx", 32'(out_idx), 2);
`else
    chk("sign_max", 32'(out_max), 32'h3F);
    chk("sign_idx", 32'(out_idx), 0);
`endif
    repeat (3) tick();
    chk("sb_drained", 32'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/max_frame_sched.md
Name: max_frame_sched

Overview:
- Sequential scheduler around a single unsigned max-compare datapath.
- Accepts a frame of cfg_len samples over a valid/ready stream, one compare per accepted sample.
- Keeps a running maximum and the index of that maximum.
- Presents {max, index} on an output valid/ready port when the frame ends.
- Sits between the sample source and the consumer of the reduced result.

Parameters:
- DATA_W, 6, sample width in bits
- LEN_W, 8, width of the frame-length field and of the index

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a new frame; sampled in IDLE, or in DONE on the output-handshake cycle
- cfg_len  input  LEN_W  frame length in samples; latched on accepted start
- in_valid  input  1  sample valid
- in_ready  output  1  scheduler can take a sample
- in_data  input  DATA_W  sample value
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_max  output  DATA_W  frame maximum
- out_idx  output  LEN_W  0-based index of the maximum within the frame
- busy  output  1  high in ACCUM and DONE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - in_ready=0, out_valid=0, busy=0.
  - out_max=0, out_idx=0.
  - Internal counter and length register cleared.
- Reset mid-frame: the frame is abandoned immediately and no result is produced.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - in_ready=0.
  - start=1 with cfg_len!=0: latch len=cfg_len, cnt=0, go to ACCUM on the next edge.
  - start=1 with cfg_len==0: ignored, stay IDLE.
- ACCUM:
  - in_ready=1.
  - A sample is accepted on an edge where in_valid && in_ready.
  - First accepted sample (cnt==0) loads cur_max=in_data and cur_idx=0 unconditionally.
  - Each later sample replaces cur_max/cur_idx only if in_data > cur_max (strict, unsigned). Ties keep the earliest index.
  - cnt increments on each accept.
  - On the accept where cnt==len-1: go to DONE. out_max/out_idx take the final values, and out_valid=1 from the next cycle. Latency is 1 cycle from the last accept to out_valid.
  - start is ignored in ACCUM.
- DONE:
  - in_ready=0.
  - out_valid=1, with out_max/out_idx held stable until the handshake.
  - On out_valid && out_ready: out_valid drops next cycle.
  - If start=1 and cfg_len!=0 on that same handshake cycle: go directly to ACCUM (back-to-back frame, no IDLE bubble), latching the new len.
  - Otherwise go to IDLE.
  - start without out_ready is ignored.
- in_ready depends only on state, never combinationally on in_valid. out_valid is registered.
- out_max/out_idx hold the last result after leaving DONE until the next frame completes.
- Length len=2^LEN_W-1 is the maximum. The counter never wraps within a frame.
- in_data is don't-care when in_valid=0. Idle cycles inside ACCUM do not advance cnt.

Optional Feature:
- Macro: MAX_FRAME_SCHED_SIGNED_EN
- Defined: samples and out_max are two's-complement. The comparison is signed (in_data > cur_max, signed). Reset value of out_max stays 0.
- Undefined: unsigned comparison as specified above.
- The tie rule (keep earliest index) and all timing are identical in both builds.

Test Plan:
- Basic: cfg_len=4, samples 3,9,2,7 with in_valid every cycle -> out_valid one cycle after 4th accept; out_max=9, out_idx=1; in_ready=0 in DONE.
- Ties and bubbles: cfg_len=5, samples 5,12,12,0,12 with in_valid gaps of 0-3 cycles -> out_max=12, out_idx=1; cnt unaffected by gaps.
- Backpressure and back-to-back: hold out_ready=0 for 6 cycles -> out_max/out_idx stable, start ignored. Then out_ready=1 with start=1, cfg_len=2, followed by samples 1,63 -> next result out_max=63, out_idx=1, with no IDLE cycle between frames.
- Degenerate lengths:
  - cfg_len=0 start -> stays IDLE, busy=0.
  - cfg_len=1, sample 0 -> out_max=0, out_idx=0.
- Reset mid-frame: assert rst_n=0 after 2 of 4 samples -> all outputs 0 asynchronously. Restart with cfg_len=3, samples 4,1,4 -> out_max=4, out_idx=0.
- Signed build (MAX_FRAME_SCHED_SIGNED_EN): cfg_len=3, samples 6'h3F (-1), 6'h20 (-32), 6'h01 -> out_max=6'h01, out_idx=2. Same stimulus in the unsigned build -> out_max=6'h3F, out_idx=0.
